// File: rtl/cpu6_dmem_responder.sv
// cpu6_dmem_responder
//   Responder for the cpu6 MEM-stage data port. Each access is decoded to a word RAM, a small
//   MMIO block (bus-error capture and optional machine timer), or a miss. Read data is
//   combinational, so the load completes in its own MEM cycle. Stores commit on posedge clk.
//
//   Optional feature macro: CPU6_DMEM_MTIMER_EN
//     Defined:   machine timer (MTIME, MTIMECMP, irq_timer) is built. The MMIO window is 0x00-0x17.
//     Undefined: there is no timer logic, and irq_timer is tied 0. The MMIO window is 0x00-0x07.
//                Offsets 0x08-0x14 then decode as misses.
//
// Ports
//   clk         in   1   clock
//   reset       in   1   asynchronous reset, active-low
//   dataaddrM   in   32  byte address from the MEM stage
//   writedataM  in   32  store data
//   memwriteM   in   1   store strobe
//   memreadM    in   1   load qualifier; it only affects error capture
//   readdataM   out  32  load data, combinational from dataaddrM
//   irq_timer   out  1   registered (mtime >= mtimecmp)
//   bus_err     out  1   sticky bus-error flag
//
// MMIO map (offset from MMIO_BASE)
//   0x00 ERR          R: {31'b0, bus_err}  W: clear bus_err
//   0x04 ERR_ADDR     R: address of the first miss since the last clear
//   0x08 MTIME_LO     RW (timer build only)
//   0x0C MTIME_HI     RW (timer build only)
//   0x10 MTIMECMP_LO  RW (timer build only)
//   0x14 MTIMECMP_HI  RW (timer build only)

module cpu6_dmem_responder #(
    parameter int unsigned RAM_AW    = 10,
    parameter logic [31:0] RAM_BASE  = 32'h0000_0000,
    parameter logic [31:0] MMIO_BASE = 32'h0200_0000,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dataaddrM,
    input  logic [31:0] writedataM,
    input  logic        memwriteM,
    input  logic        memreadM,
    output logic [31:0] readdataM,
    output logic        irq_timer,
    output logic        bus_err
);

    if (TICK_DIV < 1) begin : g_bad_tick_div
        $error("TICK_DIV must be at least 1");
    end

    localparam int unsigned RamTop = RAM_AW + 2;

    localparam logic [2:0] OffErr     = 3'd0;
    localparam logic [2:0] OffErrAddr = 3'd1;
`ifdef CPU6_DMEM_MTIMER_EN
    localparam logic [2:0] OffMtimeLo = 3'd2;
    localparam logic [2:0] OffMtimeHi = 3'd3;
    localparam logic [2:0] OffCmpLo   = 3'd4;
    localparam logic [2:0] OffCmpHi   = 3'd5;
    localparam logic [31:0] MmioSpan  = 32'h18;
`else
    localparam logic [31:0] MmioSpan  = 32'h08;
`endif

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic              aligned;
    logic              ram_hit;
    logic              mmio_hit;
    logic              miss;
    logic [31:0]       mmio_off;
    logic [2:0]        mmio_idx;
    logic [RAM_AW-1:0] ram_idx;
    logic              mmio_we;

    assign aligned  = (dataaddrM[1:0] == 2'b00);
    // RAM_BASE is aligned to the RAM size, so matching the upper bits is the range check.
    assign ram_hit  = aligned && (dataaddrM[31:RamTop] == RAM_BASE[31:RamTop]);
    assign mmio_off = dataaddrM - MMIO_BASE;
    assign mmio_hit = aligned && (dataaddrM >= MMIO_BASE) && (mmio_off < MmioSpan);
    assign miss     = !ram_hit && !mmio_hit;
    assign mmio_idx = mmio_off[4:2];
    assign ram_idx  = dataaddrM[RAM_AW+1:2];
    assign mmio_we  = memwriteM && mmio_hit;

    // ------------------------------------------------------------------
    // Word RAM (contents are not reset)
    // ------------------------------------------------------------------
    logic [31:0] mem [2**RAM_AW];

    // Gating on reset drops a store that is in flight when reset is asserted.
    always_ff @(posedge clk) begin
        if (reset && memwriteM && ram_hit) begin
            mem[ram_idx] <= writedataM;
        end
    end

    // ------------------------------------------------------------------
    // Bus-error capture
    // ------------------------------------------------------------------
    logic        bus_err_q;
    logic [31:0] err_addr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_err_q  <= 1'b0;
            err_addr_q <= '0;
        end else if ((memwriteM || memreadM) && miss) begin
            // The first error is kept until software clears the flag.
            if (!bus_err_q) begin
                bus_err_q  <= 1'b1;
                err_addr_q <= dataaddrM;
            end
        end else if (mmio_we && (mmio_idx == OffErr)) begin
            bus_err_q <= 1'b0;
        end
    end

    assign bus_err = bus_err_q;

    // ------------------------------------------------------------------
    // Machine timer
    // ------------------------------------------------------------------
`ifdef CPU6_DMEM_MTIMER_EN
    localparam int unsigned PrescW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PrescW-1:0] presc_q, presc_d;
    logic              tick;
    logic [63:0]       mtime_q, mtime_d;
    logic [63:0]       mtimecmp_q, mtimecmp_d;
    logic              irq_q;

    assign tick = (presc_q == PrescW'(TICK_DIV - 1));

    always_comb begin
        presc_d    = tick ? '0 : presc_q + 1'b1;
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = mtimecmp_q;
        // A software write replaces the tick; the other half holds, so no carry is applied.
        if (mmio_we) begin
            case (mmio_idx)
                OffMtimeLo: mtime_d    = {mtime_q[63:32], writedataM};
                OffMtimeHi: mtime_d    = {writedataM, mtime_q[31:0]};
                OffCmpLo:   mtimecmp_d = {mtimecmp_q[63:32], writedataM};
                OffCmpHi:   mtimecmp_d = {writedataM, mtimecmp_q[31:0]};
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q    <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            irq_q      <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            irq_q      <= (mtime_q >= mtimecmp_q);
        end
    end

    assign irq_timer = irq_q;
`else
    assign irq_timer = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        readdataM = '0;
        if (ram_hit) begin
            readdataM = mem[ram_idx];
        end else if (mmio_hit) begin
            case (mmio_idx)
                OffErr:     readdataM = {31'b0, bus_err_q};
                OffErrAddr: readdataM = err_addr_q;
`ifdef CPU6_DMEM_MTIMER_EN
                OffMtimeLo: readdataM = mtime_q[31:0];
                OffMtimeHi: readdataM = mtime_q[63:32];
                OffCmpLo:   readdataM = mtimecmp_q[31:0];
                OffCmpHi:   readdataM = mtimecmp_q[63:32];
`endif
                default:    readdataM = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu6_dmem_responder.sv
module tb_cpu6_dmem_responder;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [31:0] rdata;
    logic        irq;
    logic        berr;

    int checks   = 0;
    int failures = 0;

    cpu6_dmem_responder #(.TICK_DIV(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .dataaddrM  (addr),
        .writedataM (wdata),
        .memwriteM  (we),
        .memreadM   (re),
        .readdataM  (rdata),
        .irq_timer  (irq),
        .bus_err    (berr)
    );

`ifdef CPU6_DMEM_MTIMER_EN
    logic [31:0] addr4;
    logic [31:0] rdata4;
    logic        irq4;
    logic        berr4;
    logic [31:0] zero4;
    logic        off4;

    assign addr4 = 32'h0200_0008;
    assign zero4 = 32'h0;
    assign off4  = 1'b0;

    cpu6_dmem_responder #(.TICK_DIV(4)) dut4 (
        .clk        (clk),
        .reset      (reset),
        .dataaddrM  (addr4),
        .writedataM (zero4),
        .memwriteM  (off4),
        .memreadM   (off4),
        .readdataM  (rdata4),
        .irq_timer  (irq4),
        .bus_err    (berr4)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic        re;
        logic        chk_rd;
        logic        exp_err;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    localparam int NVec = 21;
    vec_t vecs [NVec];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        we    = w;
        re    = r;
        addr  = a;
        wdata = d;
    endtask

    initial begin
        vecs = '{
            '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0014, 32'h1111_1111, 32'h0},
            '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0},
            '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF},
            '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0014, 32'h0,         32'h1111_1111},
            '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0200_0000, 32'h0,         32'h0},
            '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0013, 32'h0,         32'h0},
            '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0200_0000, 32'h0,         32'h1},
            '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0200_0004, 32'h0,         32'h13},
            '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0300_0000, 32'h0,         32'h0},
            '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0200_0004, 32'h0,         32'h13},
            '{1'b1, 1'b0, 1'b1, 1'b1, 32'h0200_0000, 32'h0,         32'h1},
            '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0200_0000, 32'h0,         32'h0},
            '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0200_0004, 32'h0000_AAAA, 32'h13},
            '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0200_0004, 32'h0,         32'h13},
            '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0012, 32'h5,         32'h0},
            '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0200_0004, 32'h0,         32'h12},
            '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF},
            '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0FFC, 32'h1234_5678, 32'h0},
            '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0FFC, 32'h0,         32'h1234_5678},
            '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_1000, 32'h0,         32'h0},
            '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0200_0004, 32'h0,         32'h12}
        };

        // Reset state
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'h0200_0004, 32'h0);
        #12;
        check("rst_bus_err", {31'b0, berr}, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        check("rst_err_addr", rdata, 32'h0);
        addr = 32'h0200_0000;
        #1;
        check("rst_err_reg", rdata, 32'h0);
        step();
        reset = 1'b1;

        // Vector table: outputs are checked mid-cycle, then the edge commits the access.
        for (int i = 0; i < NVec; i++) begin
            drive(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata);
            #2;
            if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rd);
            check($sformatf("vec%0d_bus_err", i), {31'b0, berr}, {31'b0, vecs[i].exp_err});
            step();
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0);

`ifdef CPU6_DMEM_MTIMER_EN
        begin
            bit found;
            // Fresh reset so mtime counts from 0 in both instances.
            reset = 1'b0;
            #2;
            reset = 1'b1;
            addr = 32'h0200_0008;
            for (int n = 1; n <= 12; n++) begin
                step();
                if (n == 5) check("mtime_after5", rdata, 32'd5);
                check($sformatf("div4_mtime_n%0d", n), rdata4, n / 4);
            end

            drive(1'b1, 1'b0, 32'h0200_0014, 32'h0);
            step();
            drive(1'b1, 1'b0, 32'h0200_0010, 32'd20);
            step();
            drive(1'b0, 1'b0, 32'h0200_0008, 32'h0);
            found = 1'b0;
            for (int k = 0; k < 40 && !found; k++) begin
                #1;
                if (rdata == 32'd20) begin
                    found = 1'b1;
                    check("irq_at_reach", {31'b0, irq}, 32'h0);
                    step();
                    check("irq_after_reach", {31'b0, irq}, 32'h1);
                end else begin
                    step();
                end
            end
            if (!found) begin
                checks++;
                failures++;
                $display("FAIL irq_wait: mtime never read 20 within 40 cycles");
            end

            // Write in a tick cycle wins over the increment.
            drive(1'b1, 1'b0, 32'h0200_0008, 32'h100);
            step();
            drive(1'b0, 1'b0, 32'h0200_0008, 32'h0);
            #1;
            check("mtime_wr_prio", rdata, 32'h100);
            step();
            check("mtime_after_wr", rdata, 32'h101);

            // 64-bit wrap
            drive(1'b1, 1'b0, 32'h0200_0008, 32'hFFFF_FFFF);
            step();
            drive(1'b1, 1'b0, 32'h0200_000C, 32'hFFFF_FFFF);
            step();
            drive(1'b0, 1'b0, 32'h0200_0008, 32'h0);
            #1;
            check("mtime_lo_hold", rdata, 32'hFFFF_FFFF);
            step();
            check("wrap_lo", rdata, 32'h0);
            addr = 32'h0200_000C;
            #1;
            check("wrap_hi", rdata, 32'h0);
            check("irq_before_wrap", {31'b0, irq}, 32'h1);
            step();
            check("irq_after_wrap", {31'b0, irq}, 32'h0);
        end
`else
        // Timer offsets are misses without the timer.
        drive(1'b1, 1'b0, 32'h0200_0000, 32'h0);
        step();
        check("clr_bus_err", {31'b0, berr}, 32'h0);
        drive(1'b0, 1'b1, 32'h0200_0008, 32'h0);
        #1;
        check("notimer_rdata", rdata, 32'h0);
        step();
        check("notimer_bus_err", {31'b0, berr}, 32'h1);
        drive(1'b0, 1'b0, 32'h0200_0004, 32'h0);
        #1;
        check("notimer_err_addr", rdata, 32'h0200_0008);
        check("notimer_irq", {31'b0, irq}, 32'h0);
        step();
`endif

        // End of the MMIO window is a miss in both builds.
        drive(1'b1, 1'b0, 32'h0200_0000, 32'h0);
        step();
        drive(1'b0, 1'b1, 32'h0200_0018, 32'h0);
        #1;
        check("win_end_rdata", rdata, 32'h0);
        step();
        check("win_end_bus_err", {31'b0, berr}, 32'h1);

        // Reset asserted during a store aborts it and clears state asynchronously.
        drive(1'b1, 1'b0, 32'h0000_0020, 32'hAAAA_5555);
        step();
        drive(1'b1, 1'b0, 32'h0000_0020, 32'h5555_AAAA);
        #1;
        reset = 1'b0;
        #1;
        check("async_bus_err", {31'b0, berr}, 32'h0);
        check("async_irq", {31'b0, irq}, 32'h0);
        step();
        drive(1'b0, 1'b0, 32'h0200_0008, 32'h0);
        #1;
        check("rst_mtime_lo", rdata, 32'h0);
        reset = 1'b1;
        addr = 32'h0000_0020;
        #1;
        check("aborted_store", rdata, 32'hAAAA_5555);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
